// File: rtl/modulador_trifasico_core.sv
// modulador_trifasico_core: three independent phase channels, each stepping one level at a time
// toward a clamped request and then waiting DEAD_CYCLES before it may step again.
module modulador_trifasico_core #(
   parameter int unsigned DEAD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] PhA,
   input  logic [2:0] PhB,
   input  logic [2:0] PhC,
   output logic [5:0] outA,
   output logic [5:0] outB,
   output logic [5:0] outC
);
   logic [2:0][2:0] req;
   logic [2:0][5:0] thermo;
   assign req    = {PhC, PhB, PhA};
   assign outA   = thermo[0];
   assign outB   = thermo[1];
   assign outC   = thermo[2];
   for (genvar g = 0; g < 3; g++) begin : g_ch
      logic signed [2:0] clamped;
      logic signed [2:0] target;
      logic signed [2:0] current;
      logic        [3:0] cnt;
      logic        [2:0] lvl;
      assign clamped = (req[g] == 3'b100) ? -3'sd3 : signed'(req[g]);
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            target  <= '0;
            current <= '0;
            cnt     <= '0;
         end else begin
            target <= clamped;
            if (|cnt)
               cnt <= cnt - 4'd1;
            else if (target != current) begin
               current <= (target > current) ? current + 3'sd1 : current - 3'sd1;
               cnt     <= 4'(DEAD_CYCLES);
            end
         end
      // level offset by +3 gives the count of upper switches on (0..6)
      assign lvl       = unsigned'(current) + 3'd3;
      assign thermo[g] = 6'h3f >> (3'd6 - lvl);
   end
endmodule

// File: tb/tb_modulador_trifasico_core.sv
// tb_modulador_trifasico_core: directed vector table plus randomized run against a timestamp-based level model.
module tb_modulador_trifasico_core;
   localparam int D = 2;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] pha = '0, phb = '0, phc = '0;
   logic [5:0] outa, outb, outc;
   int n_cmp = 0;
   int n_bad = 0;
   int lvl [3];
   int tgt [3];
   longint next_ok [3];
   longint cyc = 0;

   typedef struct {
      bit         rs;
      logic [2:0] a, b, c;
      int         n;
      logic [5:0] ea, eb, ec;
   } vec_t;
   vec_t tbl[$];

   modulador_trifasico_core #(.DEAD_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .PhA(pha), .PhB(phb), .PhC(phc),
      .outA(outa), .outB(outb), .outC(outc)
   );

   always #5 clk = ~clk;

   function automatic int clampf(logic [2:0] r);
      int v;
      v = r[2] ? int'(r) - 8 : int'(r);
      return (v == -4) ? -3 : v;
   endfunction

   function automatic logic [5:0] therm(int l);
      return 6'((1 << (l + 3)) - 1);
   endfunction

   task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         lvl[c] = 0;
         tgt[c] = 0;
         next_ok[c] = 0;
      end
   endtask

   task automatic model_edge();
      logic [2:0] r [3];
      r[0] = pha; r[1] = phb; r[2] = phc;
      cyc++;
      for (int c = 0; c < 3; c++) begin
         if (cyc >= next_ok[c] && tgt[c] != lvl[c]) begin
            lvl[c] += (tgt[c] > lvl[c]) ? 1 : -1;
            next_ok[c] = cyc + D + 1;
         end
         tgt[c] = clampf(r[c]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_async_a", outa, 6'b000111);
      chk("rst_async_b", outb, 6'b000111);
      chk("rst_async_c", outc, 6'b000111);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_held_a", outa, 6'b000111);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      // ramp A up, then clamp B at -4
      tbl.push_back('{1, 3'd3, 3'd0, 3'd0, 1, 6'b000111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 1, 6'b001111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 2, 6'b001111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 1, 6'b011111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 2, 6'b011111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 1, 6'b111111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'd0, 3'd0, 5, 6'b111111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'b100, 3'd0, 1, 6'b111111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'b100, 3'd0, 1, 6'b111111, 6'b000011, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'b100, 3'd0, 3, 6'b111111, 6'b000001, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'b100, 3'd0, 3, 6'b111111, 6'b000000, 6'b000111});
      tbl.push_back('{0, 3'd3, 3'b100, 3'd0, 8, 6'b111111, 6'b000000, 6'b000111});
      // simultaneous requests on all phases
      tbl.push_back('{1, 3'd1, 3'b111, 3'd2, 1, 6'b000111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd1, 3'b111, 3'd2, 1, 6'b001111, 6'b000011, 6'b001111});
      tbl.push_back('{0, 3'd1, 3'b111, 3'd2, 3, 6'b001111, 6'b000011, 6'b011111});
      // reversal on C one edge after its first step
      tbl.push_back('{1, 3'd0, 3'd0, 3'd3, 1, 6'b000111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd0, 3'd0, 3'd3, 1, 6'b000111, 6'b000111, 6'b001111});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 1, 6'b000111, 6'b000111, 6'b001111});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 1, 6'b000111, 6'b000111, 6'b001111});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 1, 6'b000111, 6'b000111, 6'b000111});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 3, 6'b000111, 6'b000111, 6'b000011});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 3, 6'b000111, 6'b000111, 6'b000001});
      tbl.push_back('{0, 3'd0, 3'd0, 3'b101, 3, 6'b000111, 6'b000111, 6'b000000});
      // idle after reset
      tbl.push_back('{1, 3'd0, 3'd0, 3'd0, 10, 6'b000111, 6'b000111, 6'b000111});

      model_reset();
      #1;
      chk("rst_init_a", outa, 6'b000111);
      chk("rst_init_b", outb, 6'b000111);
      chk("rst_init_c", outc, 6'b000111);
      @(negedge clk);
      rst = 1'b1;
      tick();

      foreach (tbl[i]) begin
         if (tbl[i].rs) begin
            {pha, phb, phc} = '0;
            do_reset();
         end
         pha = tbl[i].a;
         phb = tbl[i].b;
         phc = tbl[i].c;
         repeat (tbl[i].n) tick();
         chk($sformatf("vec%0d_a", i), outa, tbl[i].ea);
         chk($sformatf("vec%0d_b", i), outb, tbl[i].eb);
         chk($sformatf("vec%0d_c", i), outc, tbl[i].ec);
      end

      // asynchronous reset in the middle of a ramp, then restart
      {pha, phb, phc} = '0;
      do_reset();
      pha = 3'd3;
      repeat (5) tick();
      chk("midramp_pre", outa, 6'b011111);
      rst = 1'b0;
      #1;
      chk("midramp_abort", outa, 6'b000111);
      @(posedge clk);
      #1;
      chk("midramp_hold", outa, 6'b000111);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick();
      chk("restart_capture", outa, 6'b000111);
      tick();
      chk("restart_step1", outa, 6'b001111);
      repeat (3) tick();
      chk("restart_step2", outa, 6'b011111);

      // randomized run against the model
      {pha, phb, phc} = '0;
      do_reset();
      begin
         int hold [3];
         hold = '{0, 0, 0};
         for (int t = 0; t < 3000; t++) begin
            if (hold[0] == 0) begin pha = 3'($urandom); hold[0] = $urandom_range(1, 14); end
            if (hold[1] == 0) begin phb = 3'($urandom); hold[1] = $urandom_range(1, 14); end
            if (hold[2] == 0) begin phc = 3'($urandom); hold[2] = $urandom_range(1, 14); end
            for (int c = 0; c < 3; c++) hold[c]--;
            tick();
            chk("rand_a", outa, therm(lvl[0]));
            chk("rand_b", outb, therm(lvl[1]));
            chk("rand_c", outc, therm(lvl[2]));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/modulador_trifasico_core.md
MODULADOR_TRIFASICO_CORE -- requirements
Module: ModuladorTrifasico

Interface
REQ-001 Parameter: DEAD_CYCLES, default 2, idle cycles inserted after every level step (legal 0..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (rst=0 resets immediately; released synchronously by design convention of the source driving it).
REQ-004 PhA  input  3  signed two's-complement level request, phase A.
REQ-005 PhB  input  3  signed two's-complement level request, phase B.
REQ-006 PhC  input  3  signed two's-complement level request, phase C.
REQ-007 outA  output  6  gate-enable thermometer word, phase A (bit i = upper switch i on; lower switches are the complement, generated externally).
REQ-008 outB  output  6  same, phase B.
REQ-009 outC  output  6  same, phase C.

Function
REQ-010 The block SHALL implement three identical, fully independent phase channels (A, B, C); no channel SHALL affect another.
REQ-011 Each channel SHALL clamp its request to -3..+3: request -4 SHALL be treated as -3; all other codes pass unchanged.
REQ-012 Each channel SHALL register the clamped request into a target register on every rising clk edge (1 cycle input latency).
REQ-013 Each channel SHALL hold a current-level register (range -3..+3) and a dead-time counter (4 bits).
REQ-014 On a rising edge where target != current and counter == 0, current SHALL move exactly one level toward target and counter SHALL load DEAD_CYCLES.
REQ-015 On a rising edge where counter != 0, counter SHALL decrement by one and current SHALL hold.
REQ-016 On a rising edge where target == current and counter == 0, all state SHALL hold.
REQ-017 Consecutive steps SHALL therefore be spaced exactly DEAD_CYCLES+1 clock cycles; DEAD_CYCLES=0 allows one step per cycle.
REQ-018 Multi-level jumps SHALL never occur; current SHALL always differ from its previous value by at most 1.
REQ-019 If target reverses mid-ramp, the next permitted step SHALL go toward the new target; the dead-time counter in progress SHALL still complete.
REQ-020 Output SHALL be combinational from current: bit i (i=0..5) = 1 when (current+3) > i, i.e. -3->000000, -2->000001, -1->000011, 0->000111, +1->001111, +2->011111, +3->111111.
REQ-021 Outputs SHALL be glitch-free functions of registers only (no combinational path from PhX to outX).

Reset
REQ-022 While rst=0, every channel SHALL force target=0, current=0, counter=0, independent of clk.
REQ-023 While rst=0, outA=outB=outC=6'b000111 (zero-voltage level).
REQ-024 Reset asserted mid-ramp SHALL abort the ramp immediately; after release, ramping restarts from level 0 per REQ-014.

Verification
REQ-025 Reset: inputs 0, rst pulsed low -> all outputs 000111 during and after reset, no change for 10 cycles.
REQ-026 Ramp up: DEAD_CYCLES=2, PhA=+3 after reset -> outA 001111, 011111, 111111 at edges k+1, k+4, k+7 (k = edge capturing request); outB/outC stay 000111.
REQ-027 Clamp: PhB=-4 -> outB settles at 000000 after three steps, never below level -3 and never wraps.
REQ-028 Reversal: PhC=+3, then PhC=-3 one edge after first step -> outC 001111, holds through dead-time, then steps down to 000111, 000011, ... 000000, each spaced 3 cycles.
REQ-029 Simultaneous: PhA=+1, PhB=-1, PhC=+2 same edge -> outA 001111, outB 000011, outC 001111 at k+1; outC 011111 at k+4.
REQ-030 Reset mid-ramp: rst=0 asynchronously while outA=011111 -> outA 000111 immediately without clock; after release with PhA=+3 ramp restarts from 000111.
